rtc_apb_regs: RTL

RTC_APB_REGS -- requirements
Module: rtc_apb_regs

---
 rtl/rtc_pkg.sv | 65 ++++++
 rtl/rtc_alarm_ctrl.sv | 42 ++++
 rtl/rtc_apb_regs.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC register-map definitions: time record layout, register offsets,
// APB state encoding and field accessors used by the register block and its bench.
package rtc_pkg;

    typedef struct packed {
        logic [15:0] year;
        logic [3:0]  month;
        logic [4:0]  dom;
        logic [2:0]  dow;
        logic [6:0]  hours;   // {am_pm, mode_12_24, hours[4:0]}
        logic [5:0]  min;
        logic [5:0]  sec;
    } rtc_time_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;

    typedef enum logic [2:0] {
        REG_ENABLE, REG_CONFIG, REG_CUR, REG_CONST,
        REG_INIT, REG_IR_IN, REG_IR_OUT, REG_NONE
    } reg_region_e;

    localparam logic [31:0] ADDR_ENABLE = 32'h00, ADDR_CONFIG = 32'h04, ADDR_CONST = 32'h24;
    localparam logic [31:0] ADDR_CUR_SEC = 32'h08, ADDR_CUR_MIN = 32'h0C, ADDR_CUR_HOURS = 32'h10,
                            ADDR_CUR_DOW = 32'h14, ADDR_CUR_DOM = 32'h18, ADDR_CUR_MONTH = 32'h1C,
                            ADDR_CUR_YEAR = 32'h20;
    localparam logic [31:0] ADDR_INIT_SEC = 32'h28, ADDR_INIT_MIN = 32'h2C, ADDR_INIT_HOURS = 32'h30,
                            ADDR_INIT_DOW = 32'h34, ADDR_INIT_DOM = 32'h38, ADDR_INIT_MONTH = 32'h3C,
                            ADDR_INIT_YEAR = 32'h40;
    localparam logic [31:0] ADDR_IR_IN_SEC = 32'h44, ADDR_IR_IN_MIN = 32'h48, ADDR_IR_IN_HOURS = 32'h4C,
                            ADDR_IR_IN_DOW = 32'h50, ADDR_IR_IN_DOM = 32'h54, ADDR_IR_IN_MONTH = 32'h58,
                            ADDR_IR_IN_YEAR = 32'h5C;
    localparam logic [31:0] ADDR_IR_OUT_SEC = 32'h60, ADDR_IR_OUT_MIN = 32'h64, ADDR_IR_OUT_HOURS = 32'h68,
                            ADDR_IR_OUT_DOW = 32'h6C, ADDR_IR_OUT_DOM = 32'h70, ADDR_IR_OUT_MONTH = 32'h74,
                            ADDR_IR_OUT_YEAR = 32'h78;

    function automatic logic [31:0] get_field(rtc_time_t t, logic [2:0] fld);
        case (fld)
            3'd0:    return {26'd0, t.sec};
            3'd1:    return {26'd0, t.min};
            3'd2:    return {25'd0, t.hours};
            3'd3:    return {29'd0, t.dow};
            3'd4:    return {27'd0, t.dom};
            3'd5:    return {28'd0, t.month};
            3'd6:    return {16'd0, t.year};
            default: return 32'd0;
        endcase
    endfunction

    function automatic rtc_time_t set_field(rtc_time_t t, logic [2:0] fld, logic [31:0] d);
        rtc_time_t r;
        r = t;
        case (fld)
            3'd0:    r.sec   = d[5:0];
            3'd1:    r.min   = d[5:0];
            3'd2:    r.hours = d[6:0];
            3'd3:    r.dow   = d[2:0];
            3'd4:    r.dom   = d[4:0];
            3'd5:    r.month = d[3:0];
            3'd6:    r.year  = d[15:0];
            default: r = t;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rtc_alarm_ctrl.sv
// Alarm window tracking: pending sets when live time first equals IR_IN,
// clears when it first equals IR_OUT or software clears it; set has priority.
module rtc_alarm_ctrl
    import rtc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  rtc_time_t cur_time,
    input  rtc_time_t ir_in_time,
    input  rtc_time_t ir_out_time,
    input  logic      irq_clr,
    input  logic      irq_en,
    output logic      irq_pending,
    output logic      irq
);

    logic match_in, match_out, match_in_q, match_out_q;
    logic set_evt, clr_evt;

    assign match_in  = (cur_time == ir_in_time);
    assign match_out = (cur_time == ir_out_time);
    assign set_evt   = match_in & ~match_in_q;
    assign clr_evt   = (match_out & ~match_out_q) | irq_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_in_q  <= 1'b0;
            match_out_q <= 1'b0;
            irq_pending <= 1'b0;
            irq         <= 1'b0;
        end else begin
            match_in_q  <= match_in;
            match_out_q <= match_out;
            if (set_evt)
                irq_pending <= 1'b1;
            else if (clr_evt)
                irq_pending <= 1'b0;
            irq <= irq_pending & irq_en;
        end
    end

endmodule

// File: rtl/rtc_apb_regs.sv
// APB3 register block for the RTC: enable/config/prescaler, INIT and alarm
// window time fields, and a coherent snapshot of the live time for reads.
//
// state     | meaning
// ST_IDLE   | no transfer in flight; waiting for a setup phase
// ST_SETUP  | setup phase seen; this cycle is the first access cycle
// ST_ACCESS | read wait state done; second access cycle returns data
module rtc_apb_regs
    import rtc_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  rtc_time_t   cur_time,
    output rtc_time_t   init_time,
    output rtc_time_t   ir_in_time,
    output rtc_time_t   ir_out_time,
    output logic        rtc_en,
    output logic [31:0] prescale,
    output logic        init_load,
    output logic        irq
);

    apb_state_e  state, state_nxt;
    reg_region_e region;
    logic [2:0]  fld;
    logic [4:0]  widx;
    logic        addr_ok, err, wr_en, rd_en, irq_en, irq_pending, irq_clr;
    logic [31:0] rd_data, rd_q;
    logic        err_q;
    rtc_time_t   snap;

    assign widx    = paddr[6:2];
    assign addr_ok = (paddr[1:0] == 2'b00) && (paddr[31:7] == 25'd0) && (paddr[6:0] <= 7'h78);

    // Field index uses modulo-8 arithmetic on the word index; bases are 2, 10, 17, 24.
    always_comb begin
        region = REG_NONE;
        fld    = 3'd0;
        if (addr_ok) begin
            if (widx == 5'd0)       region = REG_ENABLE;
            else if (widx == 5'd1)  region = REG_CONFIG;
            else if (widx <= 5'd8)  begin region = REG_CUR;    fld = widx[2:0] - 3'd2; end
            else if (widx == 5'd9)  region = REG_CONST;
            else if (widx <= 5'd16) begin region = REG_INIT;   fld = widx[2:0] - 3'd2; end
            else if (widx <= 5'd23) begin region = REG_IR_IN;  fld = widx[2:0] - 3'd1; end
            else                    begin region = REG_IR_OUT; fld = widx[2:0];        end
        end
    end

    assign err = (region == REG_NONE) || (pwrite && region == REG_CUR);

    always_comb begin
        rd_data = 32'd0;
        case (region)
            REG_ENABLE: rd_data = {31'd0, rtc_en};
            REG_CONFIG: rd_data = {28'd0, irq_pending, 1'b0, irq_en, 1'b0};
            REG_CUR:    rd_data = (fld == 3'd0) ? get_field(cur_time, 3'd0) : get_field(snap, fld);
            REG_CONST:  rd_data = prescale;
            REG_INIT:   rd_data = get_field(init_time, fld);
            REG_IR_IN:  rd_data = get_field(ir_in_time, fld);
            REG_IR_OUT: rd_data = get_field(ir_out_time, fld);
            default:    rd_data = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'd0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (psel && !penable) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (!psel) begin
                    state_nxt = ST_IDLE;
                end else if (penable) begin
                    if (pwrite) begin
                        pready    = 1'b1;
                        pslverr   = err;
                        wr_en     = ~err;
                        state_nxt = ST_IDLE;
                    end else begin
                        rd_en     = 1'b1;
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (psel && penable) begin
                    pready  = 1'b1;
                    pslverr = err_q;
                    prdata  = rd_q;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign irq_clr = wr_en && (region == REG_CONFIG) && pwdata[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_q        <= 32'd0;
            err_q       <= 1'b0;
            snap        <= '0;
            rtc_en      <= 1'b0;
            irq_en      <= 1'b0;
            init_load   <= 1'b0;
            prescale    <= PRESCALE_RST;
            init_time   <= '0;
            ir_in_time  <= '0;
            ir_out_time <= '0;
        end else begin
            state     <= state_nxt;
            init_load <= wr_en && (region == REG_CONFIG) && pwdata[0];
            if (rd_en) begin
                rd_q  <= err ? 32'd0 : rd_data;
                err_q <= err;
                if (!err && region == REG_CUR && fld == 3'd0) snap <= cur_time;
            end
            if (wr_en) begin
                case (region)
                    REG_ENABLE: rtc_en      <= pwdata[0];
                    REG_CONFIG: irq_en      <= pwdata[1];
                    REG_CONST:  prescale    <= pwdata;
                    REG_INIT:   init_time   <= set_field(init_time, fld, pwdata);
                    REG_IR_IN:  ir_in_time  <= set_field(ir_in_time, fld, pwdata);
                    REG_IR_OUT: ir_out_time <= set_field(ir_out_time, fld, pwdata);
                    default: ;
                endcase
            end
        end
    end

    rtc_alarm_ctrl u_alarm (
        .clk         (clk),
        .rst         (rst),
        .cur_time    (cur_time),
        .ir_in_time  (ir_in_time),
        .ir_out_time (ir_out_time),
        .irq_clr     (irq_clr),
        .irq_en      (irq_en),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

endmodule
